// File: rtl/decoder_pipe.sv
// Pipelined binary-index decoder (one-hot / thermometer / active-low one-hot) with a
// valid/ready handshake and a 2-entry output skid buffer.
module decoder_pipe #(
   parameter int unsigned IN_W = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [IN_W-1:0]           in_data,
   input  logic [1:0]                in_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [(2**IN_W)-1:0]      out_data,
   output logic                      out_err
);

   localparam int unsigned OUT_W = 2 ** IN_W;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e             state_q;
   logic [OUT_W-1:0]   head_data_q, tail_data_q;
   logic               head_err_q, tail_err_q;

   logic [OUT_W-1:0]   onehot, dec_word;
   logic               dec_err;
   logic               push, pop;

   // Thermometer is derived from the one-hot: (onehot << 1) - 1 sets bits 0..k, and wraps to
   // all-ones when k is the top index.
   always_comb begin
      onehot          = '0;
      onehot[in_data] = 1'b1;
      dec_word        = '0;
      dec_err         = 1'b0;
      case (in_mode)
         2'b00:   dec_word = onehot;
         2'b01:   dec_word = (onehot << 1) - OUT_W'(1);
         2'b10:   dec_word = ~onehot;
         default: dec_err  = 1'b1;
      endcase
   end

   // in_ready depends only on registered state and rst, never on out_ready.
   assign in_ready  = (state_q != StTwo) && !rst;
   assign out_valid = (state_q != StEmpty);
   assign out_data  = head_data_q;
   assign out_err   = head_err_q;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StEmpty;
         head_data_q <= '0;
         head_err_q  <= 1'b0;
         tail_data_q <= '0;
         tail_err_q  <= 1'b0;
      end else begin
         case (state_q)
            StEmpty: begin
               if (push) begin
                  head_data_q <= dec_word;
                  head_err_q  <= dec_err;
                  state_q     <= StOne;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_data_q <= dec_word;
                  head_err_q  <= dec_err;
               end else if (push) begin
                  tail_data_q <= dec_word;
                  tail_err_q  <= dec_err;
                  state_q     <= StTwo;
               end else if (pop) begin
                  // Clear the head so out_data reads zero whenever out_valid is low.
                  head_data_q <= '0;
                  head_err_q  <= 1'b0;
                  state_q     <= StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  head_data_q <= tail_data_q;
                  head_err_q  <= tail_err_q;
                  tail_data_q <= '0;
                  tail_err_q  <= 1'b0;
                  state_q     <= StOne;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

endmodule
